ps2_host_transmitter: RTL

// - Host-to-device side of the PS/2 keyboard link. Sends one command byte to the keyboard,
//   for example 0xED set-LEDs, 0xFF reset, or 0xF4 enable.
// - Sits beside the scan-code receive/decode path and drives the shared open-drain PS2 clock/data lines.
// - Follows the request-to-send sequence, shifts out the frame on device clock edges and checks the device ACK.

---
 rtl/ps2_host_transmitter.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/ps2_host_transmitter.sv
// PS/2 host-to-device command transmitter: request-to-send, shifts a byte out on device clock falls, checks ACK.
// Build option: define PS2_TX_ACK_CHECK_EN to turn a NACK (ACK bit sampled 1) into tx_error.
module ps2_host_transmitter #(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int TIMEOUT_CYCLES = 200000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    RTS,
    SHIFT,
    ACK,
    WAIT_IDLE
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   clk_prev;
  logic                   clk_s;
  logic                   data_s;
  logic                   fall;
  logic                   timed_out;
  logic [9:0]             shift;
  logic [3:0]             bit_cnt;
  logic [INH_W-1:0]       inh_cnt;
  logic [TO_W-1:0]        to_cnt;
`ifdef PS2_TX_ACK_CHECK_EN
  logic                   nack;
`endif

  assign clk_s     = clk_sync[SYNC_STAGES-1];
  assign data_s    = data_sync[SYNC_STAGES-1];
  assign fall      = clk_prev & ~clk_s;
  assign timed_out = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  // Idle PS/2 lines float high, so the synchronizers come out of reset at 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk_in};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data_in};
      clk_prev  <= clk_s;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      tx_busy     <= 1'b0;
      tx_done     <= 1'b0;
      tx_error    <= 1'b0;
      shift       <= '0;
      bit_cnt     <= '0;
      inh_cnt     <= '0;
      to_cnt      <= '0;
`ifdef PS2_TX_ACK_CHECK_EN
      nack        <= 1'b0;
`endif
    end else begin
      // NOTE: pulses default low here; any branch below overrides with a later non-blocking write.
      tx_done  <= 1'b0;
      tx_error <= 1'b0;
      case (state)
        IDLE: begin
          ps2_clk_oe  <= 1'b0;
          ps2_data_oe <= 1'b0;
          if (tx_start) begin
            shift      <= {1'b1, ~^tx_data, tx_data};
            tx_busy    <= 1'b1;
            ps2_clk_oe <= 1'b1;
            inh_cnt    <= '0;
            state      <= INHIBIT;
          end
        end
        INHIBIT: begin
          if (inh_cnt == INH_W'(INHIBIT_CYCLES - 1)) begin
            ps2_data_oe <= 1'b1;
            state       <= RTS;
          end else begin
            inh_cnt <= inh_cnt + 1'b1;
          end
        end
        RTS: begin
          ps2_clk_oe <= 1'b0;
          bit_cnt    <= '0;
          to_cnt     <= '0;
          state      <= SHIFT;
        end
        SHIFT, ACK, WAIT_IDLE: begin
          to_cnt <= fall ? '0 : to_cnt + 1'b1;
          if (timed_out && !fall) begin
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            tx_error    <= 1'b1;
            tx_busy     <= 1'b0;
            state       <= IDLE;
          end else if (state == SHIFT) begin
            if (fall) begin
              ps2_data_oe <= ~shift[0];
              shift       <= {1'b0, shift[9:1]};
              bit_cnt     <= bit_cnt + 1'b1;
              if (bit_cnt == 4'd9) state <= ACK;
            end
          end else if (state == ACK) begin
            if (fall) begin
`ifdef PS2_TX_ACK_CHECK_EN
              nack  <= data_s;
`endif
              state <= WAIT_IDLE;
            end
          end else if (clk_s && data_s) begin
`ifdef PS2_TX_ACK_CHECK_EN
            tx_done  <= ~nack;
            tx_error <= nack;
`else
            tx_done  <= 1'b1;
`endif
            tx_busy  <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
